// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial packed-BCD adder (one digit per clock, LSD first).
//
// Build option: define BCD_SUBTRACT_EN to enable subtraction. When it is enabled and the
// captured op is 1, each B digit is replaced by its nines complement before the add.
// When it is not defined, op is ignored and the block always adds.
//
// Parameters:
//   DIGITS     number of BCD digits per operand (1..16)
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set presented        in_ready   block can accept operands (IDLE)
//   a, b       BCD operands, digit 0 in [3:0]
//   cin        decimal carry-in             op         0 = add, 1 = subtract (option only)
//   sum        BCD result                   cout       carry out of the top digit
//   err        some captured digit of a or b was > 9
//   out_valid  result held on sum/cout/err  out_ready  consumer accepts result
module bcd_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  input  logic                op,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;     // captured A, shifted right one digit per cycle
  logic [W-1:0]    b_q, b_d;     // captured B, shifted right one digit per cycle
  logic [W-1:0]    acc_q, acc_d; // partial result, filled from the top down
  logic            c_q, c_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;

`ifdef BCD_SUBTRACT_EN
  logic op_q, op_d;
`else
  logic unused_op;
  assign unused_op = op;
`endif

  // Single-digit datapath on the current low digit of the captured operands.
  logic [3:0]   a_dig, b_dig, b_eff, dig;
  logic [4:0]   t;
  logic         c_nxt;
  logic         dig_bad;
  logic [W-1:0] acc_next;

  always_comb begin
    a_dig = a_q[3:0];
    b_dig = b_q[3:0];
`ifdef BCD_SUBTRACT_EN
    b_eff = op_q ? (4'd9 - b_dig) : b_dig;
`else
    b_eff = b_dig;
`endif
    t = 5'(a_dig) + 5'(b_eff) + 5'(c_q);
    if (t > 5'd9) begin
      // Decimal correction; the +6 wraps modulo 16.
      dig   = 4'(t + 5'd6);
      c_nxt = 1'b1;
    end else begin
      dig   = t[3:0];
      c_nxt = 1'b0;
    end
    dig_bad = (a_dig > 4'd9) || (b_dig > 4'd9);
    // After DIGITS shifts, the first digit produced sits in bits [3:0].
    acc_next = (acc_q >> 4) | (W'(dig) << (W - 4));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    c_d     = c_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
`ifdef BCD_SUBTRACT_EN
    op_d    = op_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
`ifdef BCD_SUBTRACT_EN
          op_d    = op;
`endif
          acc_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        c_d   = c_nxt;
        acc_d = acc_next;
        err_d = err_q | dig_bad;
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          sum_d   = acc_next;
          cout_d  = c_nxt;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD_SUBTRACT_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
`ifdef BCD_SUBTRACT_EN
      op_q    <= op_d;
`endif
    end
  end

  // The state register resets asynchronously, so in_ready reads 1 throughout reset.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS = 2): directed cases plus randomized
// transactions compared against a decimal-arithmetic reference model.
module tb_bcd_serial_adder;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned W      = 4 * DIGITS;
`ifdef BCD_SUBTRACT_EN
  localparam bit SubEn = 1'b1;
`else
  localparam bit SubEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin, op;
  logic [W-1:0] sum;
  logic         cout, err, out_valid;
  logic         out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .sum       (sum),
    .cout      (cout),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: decimal value arithmetic on whole operands.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                       input logic o, output logic [W-1:0] s, output logic c,
                       output logic e);
    int unsigned an, bn, p, tot;
    logic [3:0] da, db;
    an = 0; bn = 0; p = 1; e = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      da = av[4*i +: 4];
      db = bv[4*i +: 4];
      if (da > 9 || db > 9) e = 1'b1;
      an += da * p;
      bn += db * p;
      p  *= 10;
    end
    if (SubEn && o) bn = p - 1 - bn;
    tot = an + bn + ci;
    c   = (tot >= p);
    s   = to_bcd(tot % p);
  endtask

  // Starts and ends at a negedge. Issues one operation, checks latency, handshake,
  // hold stability and the result against the model.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input logic o, input int hold, input bit iv_hold,
                        output logic [W-1:0] s_obs, output logic c_obs,
                        output logic e_obs);
    logic [W-1:0] s_exp;
    logic         c_exp, e_exp;
    int           lat;
    model(av, bv, ci, o, s_exp, c_exp, e_exp);
    check_eq("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; a = av; b = bv; cin = ci; op = o;
    @(posedge clk);
    @(negedge clk);
    // Captured copies only: scramble the inputs after acceptance.
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); op = 1'($urandom);
    lat = -1;
    for (int i = 0; i < DIGITS + 4; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      check_eq("in_ready_run", in_ready, 1'b0);
      @(negedge clk);
    end
    check_eq("latency", 64'(lat), 64'(DIGITS));
    s_obs = sum; c_obs = cout; e_obs = err;
    check_eq("err", e_obs, e_exp);
    if (!e_exp) begin
      check_eq("sum", s_obs, s_exp);
      check_eq("cout", c_obs, c_exp);
    end
    out_ready = 1'b0;
    if (iv_hold) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", out_valid, 1'b1);
      check_eq("hold_in_ready", in_ready, 1'b0);
      check_eq("hold_sum", sum, s_obs);
      check_eq("hold_cout", cout, c_obs);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("consumed_valid", out_valid, 1'b0);
    // in_ready=1 here means the FSM is in IDLE, not in RUN on a same-edge accept.
    check_eq("no_same_cycle_accept", in_ready, 1'b1);
    check_eq("sum_retained", sum, s_obs);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] s, ra, rb;
    logic         c, e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_cout", cout, 1'b0);
    check_eq("rst_err", err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Accepted on the first rising edge after release.
    run_op(8'h01, 8'h99, 1'b0, 1'b0, 0, 1'b0, s, c, e);
    check_eq("d_01_99_sum", s, 8'h00);
    check_eq("d_01_99_cout", c, 1'b1);
    check_eq("d_01_99_err", e, 1'b0);

    run_op(8'h50, 8'h49, 1'b1, 1'b0, 0, 1'b0, s, c, e);
    check_eq("d_50_49_sum", s, 8'h00);
    check_eq("d_50_49_cout", c, 1'b1);
    run_op(8'h99, 8'h99, 1'b1, 1'b0, 0, 1'b0, s, c, e);
    check_eq("d_99_99_sum", s, 8'h99);
    check_eq("d_99_99_cout", c, 1'b1);
    // Long hold with in_valid asserted in DONE, which must be ignored.
    run_op(8'h09, 8'h01, 1'b1, 1'b0, 5, 1'b1, s, c, e);
    check_eq("d_09_01_sum", s, 8'h11);
    check_eq("d_09_01_cout", c, 1'b0);

    // Reset during RUN after digit 0.
    in_valid = 1'b1; a = 8'h77; b = 8'h11; cin = 1'b0; op = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_sum", sum, 0);
    check_eq("abort_cout", cout, 1'b0);
    check_eq("abort_valid", out_valid, 1'b0);
    check_eq("abort_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DIGITS + 3; i++) begin
      @(negedge clk);
      check_eq("abort_no_valid", out_valid, 1'b0);
    end
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 1, 1'b0, s, c, e);
    check_eq("d_12_34_sum", s, 8'h46);
    check_eq("d_12_34_cout", c, 1'b0);

    run_op(8'h0A, 8'h00, 1'b0, 1'b0, 0, 1'b0, s, c, e);
    check_eq("d_0a_err", e, 1'b1);

    run_op(8'h50, 8'h49, 1'b1, 1'b1, 0, 1'b0, s, c, e);
    check_eq("d_sub1_sum", s, SubEn ? 8'h01 : 8'h00);
    check_eq("d_sub1_cout", c, 1'b1);
    run_op(8'h49, 8'h50, 1'b1, 1'b1, 0, 1'b0, s, c, e);
    check_eq("d_sub2_sum", s, SubEn ? 8'h99 : 8'h00);
    check_eq("d_sub2_cout", c, SubEn ? 1'b0 : 1'b1);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < DIGITS; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(9, 0));
        rb[4*i +: 4] = 4'($urandom_range(9, 0));
      end
      if ($urandom_range(7, 0) == 0) ra[4*$urandom_range(DIGITS-1, 0) +: 4] =
                                       4'($urandom_range(15, 10));
      if ($urandom_range(7, 0) == 0) rb[4*$urandom_range(DIGITS-1, 0) +: 4] =
                                       4'($urandom_range(15, 10));
      run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(3, 0)),
             1'($urandom), s, c, e);
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 SHALL provide parameter DIGITS, default 4, number of BCD digits per operand (legal range 1..16).
REQ-002 SHALL provide port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port in_valid  input  1  operand set presented.
REQ-005 SHALL provide port in_ready  output  1  block can accept operands.
REQ-006 SHALL provide port a  input  4*DIGITS  BCD operand A, digit 0 in bits [3:0].
REQ-007 SHALL provide port b  input  4*DIGITS  BCD operand B, same packing.
REQ-008 SHALL provide port cin  input  1  decimal carry-in.
REQ-009 SHALL provide port op  input  1  0 = add, 1 = subtract; meaningful only per REQ-030.
REQ-010 SHALL provide port sum  output  4*DIGITS  BCD result, same packing.
REQ-011 SHALL provide port cout  output  1  decimal carry-out of the most significant digit.
REQ-012 SHALL provide port err  output  1  some input digit of a or b was > 9.
REQ-013 SHALL provide port out_valid  output  1  result held on sum/cout/err.
REQ-014 SHALL provide port out_ready  input  1  consumer accepts result.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready SHALL capture a, b, cin and op into internal registers, clear digit index and err, and enter RUN.
REQ-017 RUN: SHALL process exactly one digit per cycle, least significant first, using the captured copies only; input ports are don't-care after capture.
REQ-018 Per digit SHALL compute t = a_i + b_i' + c (5 bits); if t > 9 then digit = (t + 6) mod 16 and c = 1, else digit = t and c = 0; c is initialised from cin.
REQ-019 SHALL set err if any captured a_i or b_i > 9; the digit is still processed per REQ-018 and the result is unspecified, but err is exact.
REQ-020 After digit DIGITS-1 SHALL enter DONE with sum, cout = final c, and err registered; out_valid SHALL rise exactly DIGITS cycles after the accepting edge.
REQ-021 DONE: out_valid=1, in_ready=0; sum/cout/err SHALL stay stable until out_valid&&out_ready, then the FSM SHALL enter IDLE on that edge.
REQ-022 SHALL NOT accept new operands in the same cycle a result is consumed; minimum issue interval is DIGITS+2 cycles.
REQ-023 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored.
REQ-024 sum and cout SHALL retain the last result in IDLE; they are qualified only by out_valid.
REQ-025 DIGITS=1 SHALL work: RUN lasts one cycle.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, sum=0, cout=0, err=0, out_valid=0, in_ready=1 (in_ready is driven as 1 while rst_n is low), and clear all internal registers.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation; no out_valid pulse follows deassertion.
REQ-028 First acceptance after reset release SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-029 Macro BCD_SUBTRACT_EN SHALL control subtraction support.
REQ-030 Defined: when captured op=1, each b_i SHALL be replaced by its nines complement (9 - b_i) before REQ-018; result = a + (10^DIGITS - 1 - b) + cin; true a-b uses cin=1, and cout=1 means no borrow.
REQ-031 Not defined: op SHALL be ignored, with no subtraction logic present; the block always adds. The op port still exists.

Verification (DIGITS=2 unless stated)
REQ-032 a=01, b=99, cin=0 -> sum=00, cout=1, err=0; out_valid exactly 2 cycles after the accepting edge.
REQ-033 a=50, b=49, cin=1 -> sum=00, cout=1; then a=99, b=99, cin=1 -> sum=99, cout=1; then a=09, b=01, cin=1 -> sum=11, cout=0.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> sum/cout/out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle, and the next accept occurs no earlier than one cycle later.
REQ-035 Pulse rst_n low during RUN after digit 0 -> outputs zero immediately, no out_valid afterwards; a new op 12+34 then gives sum=46, cout=0.
REQ-036 a=0A, b=00 -> err=1 with out_valid.
REQ-037 With BCD_SUBTRACT_EN defined: op=1, cin=1, a=50, b=49 -> sum=01, cout=1; a=49, b=50 -> sum=99, cout=0. Without the macro: same stimulus -> sums 00 and 00, cout 1 and 1.
